// File: rtl/operand_fetch_stage_if.sv
// Upstream (decoded instruction) and downstream (ID/EX register) handshake bundle
// for operand_fetch_stage. The stage uses the slave view; its environment uses master.
interface operand_fetch_stage_if #(
  parameter int NREG = 8,
  parameter int DW   = 16
);
  localparam int AW = $clog2(NREG);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic          in_use1;
  logic          in_use2;
  logic [AW-1:0] in_rd;
  logic          in_wen;
  logic          in_is_load;
  logic [DW-1:0] in_imm;
  logic [DW-1:0] in_pc;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_op1;
  logic [DW-1:0] out_op2;
  logic [AW-1:0] out_rd;
  logic          out_wen;
  logic          out_is_load;
  logic [DW-1:0] out_imm;
  logic [DW-1:0] out_pc;

  modport master (
    output in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wen, in_is_load,
           in_imm, in_pc, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_wen, out_is_load,
           out_imm, out_pc
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wen, in_is_load,
           in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_wen, out_is_load,
           out_imm, out_pc
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand-read stage: register-file read, EX/WB bypass, RAW and load-use
// hazard detection with a per-register pending-load scoreboard, ID/EX register.
module operand_fetch_stage #(
  parameter  int NREG = 8,
  parameter  int DW   = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_fetch_stage_if.slave  bus,
  output logic [AW-1:0]         rf_rs1,
  output logic [AW-1:0]         rf_rs2,
  input  logic [DW-1:0]         rf_rd1,
  input  logic [DW-1:0]         rf_rd2,
  input  logic                  ex_fwd_valid,
  input  logic [AW-1:0]         ex_fwd_ws,
  input  logic [DW-1:0]         ex_fwd_wd,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_ws,
  input  logic [DW-1:0]         wb_wd,
  input  logic                  wb_is_load,
  input  logic                  flush
);

  logic [1:0]    pend [NREG];
  logic [1:0]    pend1, pend2, pend_rd;
  logic          wb_load_ret;
  logic          haz1, haz2, load_guard, hazard;
  logic          in_fire, out_fire, count_load;
  logic [DW-1:0] op1, op2;

  assign rf_rs1 = bus.in_rs1;
  assign rf_rs2 = bus.in_rs2;

  assign pend1       = pend[bus.in_rs1];
  assign pend2       = pend[bus.in_rs2];
  assign pend_rd     = pend[bus.in_rd];
  assign wb_load_ret = wb_we & wb_is_load;

  always_comb begin
    op1 = rf_rd1;
    if (ex_fwd_valid && ex_fwd_ws == bus.in_rs1)  op1 = ex_fwd_wd;
    else if (wb_we && wb_ws == bus.in_rs1)        op1 = wb_wd;
    op2 = rf_rd2;
    if (ex_fwd_valid && ex_fwd_ws == bus.in_rs2)  op2 = ex_fwd_wd;
    else if (wb_we && wb_ws == bus.in_rs2)        op2 = wb_wd;
  end

  // A load retiring this very cycle as the last pending one is covered by the WB bypass.
  always_comb begin
    haz1 = bus.in_use1 &
           (((pend1 != 2'd0) &
             ~(wb_load_ret & (wb_ws == bus.in_rs1) & (pend1 == 2'd1))) |
            (bus.out_valid & bus.out_wen & (bus.out_rd == bus.in_rs1)));
    haz2 = bus.in_use2 &
           (((pend2 != 2'd0) &
             ~(wb_load_ret & (wb_ws == bus.in_rs2) & (pend2 == 2'd1))) |
            (bus.out_valid & bus.out_wen & (bus.out_rd == bus.in_rs2)));
    load_guard = bus.in_is_load & bus.in_wen & (pend_rd == 2'd3);
    hazard     = haz1 | haz2 | load_guard;
  end

  assign bus.in_ready = (~bus.out_valid | bus.out_ready) & ~hazard & ~flush;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = bus.out_valid & bus.out_ready;
  assign count_load   = out_fire & bus.out_is_load & bus.out_wen & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) pend[r] <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_op1     <= '0;
      bus.out_op2     <= '0;
      bus.out_rd      <= '0;
      bus.out_wen     <= 1'b0;
      bus.out_is_load <= 1'b0;
      bus.out_imm     <= '0;
      bus.out_pc      <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (count_load && bus.out_rd == AW'(r) && !(wb_load_ret && wb_ws == AW'(r)))
          pend[r] <= pend[r] + 2'd1;
        else if (wb_load_ret && wb_ws == AW'(r) && !(count_load && bus.out_rd == AW'(r)))
          pend[r] <= pend[r] - 2'd1;
      end
      if (flush) begin
        bus.out_valid <= 1'b0;
      end else if (in_fire) begin
        bus.out_valid   <= 1'b1;
        bus.out_op1     <= op1;
        bus.out_op2     <= op2;
        bus.out_rd      <= bus.in_rd;
        bus.out_wen     <= bus.in_wen;
        bus.out_is_load <= bus.in_is_load;
        bus.out_imm     <= bus.in_imm;
        bus.out_pc      <= bus.in_pc;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed instructions push expected
// ID/EX contents; a monitor pops and compares on every output transfer.
module tb_operand_fetch_stage;
  localparam int NREG = 8;
  localparam int DW   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rf_rs1, rf_rs2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        ex_fwd_valid;
  logic [2:0]  ex_fwd_ws;
  logic [15:0] ex_fwd_wd;
  logic        wb_we;
  logic [2:0]  wb_ws;
  logic [15:0] wb_wd;
  logic        wb_is_load;
  logic        flush;
  logic [15:0] regs [8];

  always #5 clk = ~clk;

  operand_fetch_stage_if #(.NREG(NREG), .DW(DW)) bus ();

  operand_fetch_stage #(.NREG(NREG), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_ws(ex_fwd_ws), .ex_fwd_wd(ex_fwd_wd),
    .wb_we(wb_we), .wb_ws(wb_ws), .wb_wd(wb_wd), .wb_is_load(wb_is_load),
    .flush(flush)
  );

  assign rf_rd1 = regs[rf_rs1];
  assign rf_rd2 = regs[rf_rs2];

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  rd;
    logic        wen;
    logic        is_load;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_exp, mon_act;
  int   vectors = 0;
  int   miscompares = 0;
  int   waited;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      mon_act = '{bus.out_op1, bus.out_op2, bus.out_rd, bus.out_wen, bus.out_is_load,
                  bus.out_imm, bus.out_pc};
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %h, required no transfer", mon_act);
      end else begin
        mon_exp = expq.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL out_pc_%h: got %h, required %h", mon_exp.pc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] rs1, input logic [2:0] rs2, input logic u1,
                        input logic u2, input logic [2:0] rd, input logic wen,
                        input logic ld, input logic [15:0] imm, input logic [15:0] pc);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use1    = u1;
    bus.in_use2    = u2;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
    bus.in_is_load = ld;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
  endtask

  task automatic push_exp(input logic [15:0] o1, input logic [15:0] o2);
    expq.push_back('{o1, o2, bus.in_rd, bus.in_wen, bus.in_is_load, bus.in_imm, bus.in_pc});
  endtask

  // Waits (bounded) for in_ready, completes the transfer, returns stalled cycles.
  task automatic accept(input string name, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n >= 20) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got in_ready=0 for %0d cycles, required acceptance", name, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0A00 + 16'h0101 * 16'(i);
    regs[2] = 16'h1111;
    regs[3] = 16'h2222;
    reset = 1'b1;
    flush = 1'b0;
    ex_fwd_valid = 1'b0; ex_fwd_ws = '0; ex_fwd_wd = '0;
    wb_we = 1'b0; wb_ws = '0; wb_wd = '0; wb_is_load = 1'b0;
    bus.out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    bus.in_valid = 1'b0;

    repeat (2) tick();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_op1", bus.out_op1, 0);
    check("reset_out_pc", bus.out_pc, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    tick();

    // Plain register-file read, one-cycle latency
    set_in(2, 3, 1, 1, 7, 1, 0, 16'h0011, 16'h0100);
    push_exp(16'h1111, 16'h2222);
    accept("basic", waited);
    check("latency_out_valid", bus.out_valid, 1);
    check("latency_out_pc", bus.out_pc, 16'h0100);

    // Bypass priority: EX over WB over register file
    ex_fwd_valid = 1'b1; ex_fwd_ws = 3'd5; ex_fwd_wd = 16'hAAAA;
    wb_we = 1'b1; wb_ws = 3'd5; wb_wd = 16'hBBBB; wb_is_load = 1'b0;
    set_in(5, 0, 1, 0, 0, 0, 0, 16'h0022, 16'h0102);
    push_exp(16'hAAAA, regs[0]);
    accept("fwd_ex", waited);
    ex_fwd_valid = 1'b0;
    set_in(5, 0, 1, 0, 0, 0, 0, 16'h0023, 16'h0104);
    push_exp(16'hBBBB, regs[0]);
    accept("fwd_wb", waited);
    ex_fwd_valid = 1'b1; ex_fwd_ws = 3'd5; ex_fwd_wd = 16'hDDDD;
    wb_ws = 3'd6; wb_wd = 16'hCCCC;
    set_in(6, 5, 1, 1, 0, 0, 0, 16'h0024, 16'h0106);
    push_exp(16'hCCCC, 16'hDDDD);
    accept("fwd_both", waited);
    ex_fwd_valid = 1'b0; wb_we = 1'b0;

    // Load-use: reader of R4 waits for the load's write-back
    drain();
    set_in(0, 0, 0, 0, 4, 1, 1, 16'h0030, 16'h0110);
    push_exp(regs[0], regs[0]);
    accept("load_issue", waited);
    set_in(4, 0, 1, 0, 0, 0, 0, 16'h0031, 16'h0112);
    push_exp(16'h4444, regs[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("load_use_stall", bus.in_ready, 0);
    end
    tick();
    wb_we = 1'b1; wb_is_load = 1'b1; wb_ws = 3'd4; wb_wd = 16'h4444;
    accept("load_use_release", waited);
    check("load_use_release_wait", waited, 0);
    wb_we = 1'b0; wb_is_load = 1'b0;
    set_in(4, 0, 1, 0, 0, 0, 0, 16'h0032, 16'h0114);
    push_exp(regs[4], regs[0]);
    accept("pend4_cleared", waited);
    check("pend4_cleared_wait", waited, 0);

    // ALU writer then dependent reader: exactly one bubble
    drain();
    set_in(2, 3, 1, 1, 1, 1, 0, 16'h0040, 16'h0120);
    push_exp(16'h1111, 16'h2222);
    accept("raw_writer", waited);
    set_in(1, 3, 1, 1, 0, 0, 0, 16'h0041, 16'h0122);
    push_exp(16'h5555, 16'h2222);
    @(negedge clk);
    check("raw_stall", bus.in_ready, 0);
    tick();
    ex_fwd_valid = 1'b1; ex_fwd_ws = 3'd1; ex_fwd_wd = 16'h5555;
    @(negedge clk);
    check("raw_bubble", bus.out_valid, 0);
    check("raw_reader_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    ex_fwd_valid = 1'b0;

    // Backpressure holds the output register stable
    drain();
    bus.out_ready = 1'b0;
    set_in(2, 3, 1, 1, 0, 0, 0, 16'h0050, 16'h0200);
    push_exp(16'h1111, 16'h2222);
    accept("bp_first", waited);
    set_in(3, 2, 1, 1, 0, 0, 0, 16'h0051, 16'h0202);
    push_exp(16'h2222, 16'h1111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_pc", bus.out_pc, 16'h0200);
      check("bp_out_op1", bus.out_op1, 16'h1111);
    end
    tick();
    bus.out_ready = 1'b1;
    accept("bp_release", waited);
    check("bp_release_wait", waited, 0);
    check("bp_capture_pc", bus.out_pc, 16'h0202);

    // Flush of a held load: not counted in the scoreboard
    drain();
    bus.out_ready = 1'b0;
    set_in(0, 0, 0, 0, 6, 1, 1, 16'h0060, 16'h0300);
    accept("flush_load", waited);
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_in", bus.in_ready, 0);
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_kills", bus.out_valid, 0);
    set_in(6, 0, 1, 0, 0, 0, 0, 16'h0061, 16'h0302);
    push_exp(regs[6], regs[0]);
    accept("flush_no_pend", waited);
    check("flush_no_pend_wait", waited, 0);

    // Reset in the middle of a stall clears scoreboard and output register
    drain();
    set_in(0, 0, 0, 0, 3, 1, 1, 16'h0070, 16'h0400);
    push_exp(regs[0], regs[0]);
    accept("rst_load", waited);
    tick();
    bus.out_ready = 1'b0;
    set_in(0, 0, 0, 0, 2, 0, 0, 16'h0071, 16'h0402);
    accept("rst_filler", waited);
    set_in(3, 0, 1, 0, 0, 0, 0, 16'h0072, 16'h0404);
    push_exp(regs[3], regs[0]);
    @(negedge clk);
    check("pre_reset_stall", bus.in_ready, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_out_valid", bus.out_valid, 0);
    check("reset_mid_out_pc", bus.out_pc, 0);
    bus.out_ready = 1'b1;
    accept("reset_clears_pend", waited);
    check("reset_clears_pend_wait", waited, 0);

    drain();
    tick();
    check("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-read pipeline stage that sits directly upstream of the EX stage and drives the read ports of the 8x16 general-purpose register file.
- Accepts decoded instruction fields from fetch/decode over a valid/ready handshake and reads both source operands from the register file.
- Bypasses results from EX and WB, detects RAW and load-use hazards with a per-register pending-load scoreboard, and registers the operands into an ID/EX output register.

Parameters:
- NREG, 8, number of architectural registers (address width is clog2(NREG) = 3)
- DW, 16, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  3 each  source register addresses
- in_use1, in_use2  in  1 each  source is actually read
- in_rd  in  3  destination register
- in_wen  in  1  instruction writes in_rd
- in_is_load  in  1  instruction is a memory load
- in_imm, in_pc  in  16 each  passthrough fields
- rf_rs1, rf_rs2  out  3 each  register file read addresses (combinational copies of in_rs1/in_rs2)
- rf_rd1, rf_rd2  in  16 each  register file read data (combinational)
- ex_fwd_valid  in  1  EX holds a non-load result this cycle
- ex_fwd_ws  in  3  EX destination register
- ex_fwd_wd  in  16  EX result
- wb_we  in  1  write-back strobe (same signal as the register file write enable)
- wb_ws  in  3  write-back register
- wb_wd  in  16  write-back data
- wb_is_load  in  1  write-back originates from a load
- flush  in  1  kill the instruction in this stage (branch redirect)
- out_valid  out  1  ID/EX register valid
- out_ready  in  1  EX accepts
- out_op1, out_op2  out  16 each  resolved operands
- out_rd, out_wen, out_is_load, out_imm, out_pc  out  registered passthroughs

Behaviour:
- Reset (synchronous): out_valid=0; all out_* data=0; all scoreboard counters=0.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- Fire events: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.

Operand select, per source, priority high to low:
1. ex_fwd_valid & ex_fwd_ws==rs → ex_fwd_wd
2. wb_we & wb_ws==rs → wb_wd (the register file writes at the edge, so its read data is stale this cycle)
3. otherwise rf_rd*
- A source with in_use*=0 still loads an operand but never causes a hazard.

Scoreboard:
- One 2-bit counter per register, pend[r].
- +1 on out_fire & out_is_load & out_wen for out_rd.
- −1 on wb_we & wb_is_load for wb_ws.
- Increment and decrement of the same register in one cycle leaves it unchanged.

Hazard (per used source rs):
- (a) pend[rs]!=0 and not (wb_we & wb_is_load & wb_ws==rs & pend[rs]==1), or
- (b) out_valid & out_wen & out_rd==rs. This is a RAW hazard on the instruction leaving this stage; it costs a 1-cycle bubble, after which EX forwarding supplies the value.
- Load issue guard: also stall if in_is_load & in_wen & pend[in_rd]==3.

Handshake:
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- in_ready must not depend on in_valid.
- Output register update:
  - flush → out_valid=0 (flush has priority over everything)
  - else in_fire → load all out_*, out_valid=1
  - else out_fire → out_valid=0
  - else hold; out_* stay stable while out_valid & ~out_ready.
- Flush: a load flushed in the out register is never counted. Scoreboard decrements still apply during flush, because older loads keep retiring.
- Stalled cycles: out_valid drops to 0 (bubble) if out_fire and no in_fire.

Test Plan:
- Reset, then in rs1=2, rs2=3 with rf_rd1=0x1111, rf_rd2=0x2222 and out_ready=1 → after 1 edge: out_valid=1, op1=0x1111, op2=0x2222.
- Forward priority: rs1=5, ex_fwd(5,0xAAAA), wb(5,0xBBBB) → op1=0xAAAA; drop ex_fwd → op1=0xBBBB.
- Load-use: load R4 issues; next instruction uses R4 → in_ready=0 until the cycle wb_we&wb_is_load&wb_ws=4, then accepted with op=wb_wd; pend[4] returns to 0.
- Back-to-back ALU writer R1 then reader of R1 → exactly one bubble cycle (out_valid=0), then reader accepted taking ex_fwd_wd.
- Backpressure: out_ready=0 for 3 cycles → out_* stable, in_ready=0; release → next instruction captured.
- Flush while out holds a load to R6 → out_valid=0, pend[6] stays 0; reset asserted mid-stall → all counters and out_valid cleared next edge.
